plru_victim_select: RTL and testbench

- Per-set tree pseudo-LRU replacement unit for an N-way set-associative cache.
- Holds WAYS-1 PLRU bits for each of SETS sets and updates them on every hit or fill.
- Answers victim requests with a registered way index, one request per cycle, fully pipelined.
- Sits beside the cache tag/valid/dirty arrays and feeds the cache controller's fill/writeback path.

---
 rtl/plru_victim_select.sv | 126 ++++++++++++
 tb/tb_plru_victim_select.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/plru_victim_select.sv
// Per-set tree pseudo-LRU victim selector with registered, fully pipelined responses.
// Optional macro CLEAN_PREF_EN: prefer the lowest clean way over a dirty PLRU leaf.
module plru_victim_select #(
  parameter int WAYS = 4,
  parameter int SETS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    access_valid,
  input  logic [$clog2(SETS)-1:0] access_set,
  input  logic [$clog2(WAYS)-1:0] access_way,
  input  logic                    clear_set,
  input  logic                    victim_req,
  input  logic [$clog2(SETS)-1:0] victim_set,
  input  logic [WAYS-1:0]         valid_vec,
  input  logic [WAYS-1:0]         dirty_vec,
  output logic                    victim_valid,
  output logic [$clog2(WAYS)-1:0] victim_way,
  output logic                    victim_dirty,
  output logic [$clog2(SETS)-1:0] victim_set_out
);

  localparam int WW = $clog2(WAYS);
  localparam int NB = WAYS - 1;

  logic [NB-1:0] plru_q [SETS];

  // Heap-ordered tree: the node at level l covering leaf w is (2^l - 1) + (w >> (WW - l)).
  function automatic logic [NB-1:0] touch(input logic [NB-1:0] bits, input logic [WW-1:0] way);
    logic [NB-1:0] r;
    r = bits;
    for (int l = 0; l < WW; l++) begin
      for (int p = 0; p < (1 << l); p++) begin
        if ((int'(way) >> (WW - l)) == p)
          r[(1 << l) - 1 + p] = ~way[WW-1-l];
      end
    end
    return r;
  endfunction

  function automatic logic [WW-1:0] tree_leaf(input logic [NB-1:0] bits);
    logic [WW-1:0] leaf;
    logic          hit;
    leaf = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit = 1'b1;
      for (int l = 0; l < WW; l++) begin
        if (bits[(1 << l) - 1 + (w >> (WW - l))] != w[WW-1-l])
          hit = 1'b0;
      end
      if (hit)
        leaf = WW'(w);
    end
    return leaf;
  endfunction

  // Returns {found, index} of the lowest-index zero bit.
  function automatic logic [WW:0] first_zero(input logic [WAYS-1:0] v);
    logic [WW:0] r;
    r = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!v[w])
        r = {1'b1, WW'(w)};
    end
    return r;
  endfunction

  logic [NB-1:0] cur_bits;
  logic [NB-1:0] fwd_bits;
  logic [WW-1:0] leaf;
  logic [WW:0]   inv;
  logic [WW-1:0] sel_way;
  logic          sel_dirty;
`ifdef CLEAN_PREF_EN
  logic [WW:0]   cln;
`endif

  always_comb begin
    cur_bits = plru_q[victim_set];
    if (clear_set && (access_set == victim_set))
      fwd_bits = '0;
    else if (access_valid && (access_set == victim_set))
      fwd_bits = touch(cur_bits, access_way);
    else
      fwd_bits = cur_bits;

    leaf    = tree_leaf(fwd_bits);
    inv     = first_zero(valid_vec);
    sel_way = leaf;
`ifdef CLEAN_PREF_EN
    cln = first_zero(dirty_vec);
    if (inv[WW])
      sel_way = inv[WW-1:0];
    else if (dirty_vec[leaf] && cln[WW])
      sel_way = cln[WW-1:0];
`else
    if (inv[WW])
      sel_way = inv[WW-1:0];
`endif
    sel_dirty = valid_vec[sel_way] & dirty_vec[sel_way];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++)
        plru_q[s] <= '0;
      victim_valid   <= 1'b0;
      victim_way     <= '0;
      victim_dirty   <= 1'b0;
      victim_set_out <= '0;
    end else begin
      if (clear_set)
        plru_q[access_set] <= '0;
      else if (access_valid)
        plru_q[access_set] <= touch(plru_q[access_set], access_way);

      victim_valid <= victim_req;
      if (victim_req) begin
        victim_way     <= sel_way;
        victim_dirty   <= sel_dirty;
        victim_set_out <= victim_set;
      end
    end
  end

endmodule

// File: tb/tb_plru_victim_select.sv
// Self-checking bench for plru_victim_select (WAYS=4, SETS=8) against a range-bisection PLRU model.
module tb_plru_victim_select;

  logic       clk = 1'b0;
  logic       reset;
  logic       access_valid;
  logic [2:0] access_set;
  logic [1:0] access_way;
  logic       clear_set;
  logic       victim_req;
  logic [2:0] victim_set;
  logic [3:0] valid_vec;
  logic [3:0] dirty_vec;
  logic       victim_valid;
  logic [1:0] victim_way;
  logic       victim_dirty;
  logic [2:0] victim_set_out;

  int errors = 0;
  int checks = 0;

  bit mdl [8][3];

  plru_victim_select #(.WAYS(4), .SETS(8)) dut (
    .clk(clk), .reset(reset),
    .access_valid(access_valid), .access_set(access_set), .access_way(access_way),
    .clear_set(clear_set),
    .victim_req(victim_req), .victim_set(victim_set),
    .valid_vec(valid_vec), .dirty_vec(dirty_vec),
    .victim_valid(victim_valid), .victim_way(victim_way),
    .victim_dirty(victim_dirty), .victim_set_out(victim_set_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic void mdl_reset();
    for (int s = 0; s < 8; s++)
      for (int n = 0; n < 3; n++)
        mdl[s][n] = 1'b0;
  endfunction

  // Walk down the way range; each node points at the half that was not just used.
  function automatic void mdl_touch(input int s, input int way);
    int lo = 0, hi = 4, node = 0, mid;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (way < mid) begin
        mdl[s][node] = 1'b1; hi = mid; node = 2 * node + 1;
      end else begin
        mdl[s][node] = 1'b0; lo = mid; node = 2 * node + 2;
      end
    end
  endfunction

  function automatic int mdl_victim(input int s, input bit [3:0] vv, input bit [3:0] dv);
    int lo = 0, hi = 4, node = 0, mid;
    for (int w = 0; w < 4; w++)
      if (!vv[w]) return w;
    while (hi - lo > 1) begin
      mid = (lo + hi) / 2;
      if (mdl[s][node]) begin
        lo = mid; node = 2 * node + 2;
      end else begin
        hi = mid; node = 2 * node + 1;
      end
    end
`ifdef CLEAN_PREF_EN
    if (dv[lo])
      for (int w = 0; w < 4; w++)
        if (!dv[w]) return w;
`endif
    return lo;
  endfunction

  // One clock: drive, predict (post-update state for forwarding), clock, check the response.
  task automatic cyc(input string tag, input bit av, input int as, input int aw, input bit cs,
                     input bit vr, input int vs, input bit [3:0] vv, input bit [3:0] dv);
    int ew;
    bit ed;
    access_valid = av; access_set = 3'(as); access_way = 2'(aw); clear_set = cs;
    victim_req = vr; victim_set = 3'(vs); valid_vec = vv; dirty_vec = dv;
    if (cs)
      for (int n = 0; n < 3; n++) mdl[as][n] = 1'b0;
    else if (av)
      mdl_touch(as, aw);
    ew = mdl_victim(vs, vv, dv);
    ed = vv[ew] & dv[ew];
    @(posedge clk); #1;
    chk({tag, "_valid"}, int'(victim_valid), int'(vr));
    if (vr) begin
      chk({tag, "_way"}, int'(victim_way), ew);
      chk({tag, "_dirty"}, int'(victim_dirty), int'(ed));
      chk({tag, "_set"}, int'(victim_set_out), vs);
    end
  endtask

  task automatic idle();
    cyc("idle", 0, 0, 0, 0, 0, 0, 4'hF, 4'h0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    mdl_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    access_valid = 0; access_set = 0; access_way = 0; clear_set = 0;
    victim_req = 0; victim_set = 0; valid_vec = 4'hF; dirty_vec = 4'h0;
    mdl_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_valid", int'(victim_valid), 0);
    chk("rst_way", int'(victim_way), 0);
    chk("rst_dirty", int'(victim_dirty), 0);
    chk("rst_set", int'(victim_set_out), 0);
    reset = 1'b0;

    cyc("first", 0, 0, 0, 0, 1, 3, 4'hF, 4'h0);

    cyc("acc2", 1, 3, 2, 0, 0, 0, 4'hF, 4'h0);
    cyc("acc0", 1, 3, 0, 0, 0, 0, 4'hF, 4'h0);
    cyc("acc3", 1, 3, 3, 0, 0, 0, 4'hF, 4'h0);
    cyc("acc1", 1, 3, 1, 0, 0, 0, 4'hF, 4'h0);
    cyc("set3", 0, 0, 0, 0, 1, 3, 4'hF, 4'h0);
    chk("set3_is2", int'(victim_way), 2);
    cyc("set4", 0, 0, 0, 0, 1, 4, 4'hF, 4'h0);
    chk("set4_is0", int'(victim_way), 0);

    cyc("inv1011", 0, 0, 0, 0, 1, 3, 4'b1011, 4'hF);
    cyc("inv0000", 0, 0, 0, 0, 1, 3, 4'b0000, 4'hF);

    cyc("clr3", 0, 3, 0, 1, 1, 3, 4'hF, 4'h0);

    do_reset();
    cyc("fwd_same", 1, 5, 0, 0, 1, 5, 4'hF, 4'h0);
    chk("fwd_same_is2", int'(victim_way), 2);
    do_reset();
    cyc("fwd_other", 1, 6, 0, 0, 1, 5, 4'hF, 4'h0);
    chk("fwd_other_is0", int'(victim_way), 0);

    do_reset();
    cyc("dirty", 0, 0, 0, 0, 1, 2, 4'hF, 4'b0011);
`ifdef CLEAN_PREF_EN
    chk("dirty_way", int'(victim_way), 2);
`else
    chk("dirty_way", int'(victim_way), 0);
`endif
    cyc("alldirty", 0, 0, 0, 0, 1, 2, 4'hF, 4'hF);

    // Request in flight when reset asserts must not produce a response.
    cyc("prep", 1, 1, 0, 0, 0, 0, 4'hF, 4'h0);
    victim_req = 1'b1; victim_set = 3'd1; access_valid = 1'b0;
    #2 reset = 1'b1;
    mdl_reset();
    @(posedge clk); #1;
    chk("rst_drop", int'(victim_valid), 0);
    @(posedge clk); #1;
    chk("rst_ignore", int'(victim_valid), 0);
    reset = 1'b0;
    victim_req = 1'b0;
    cyc("after_rst", 0, 0, 0, 0, 1, 1, 4'hF, 4'h0);
    chk("after_rst_is0", int'(victim_way), 0);

    for (int i = 0; i < 4; i++)
      cyc("burst", 1, i, i, 0, 1, i, 4'hF, 4'h0);
    idle();

    for (int i = 0; i < 400; i++) begin
      bit [3:0] vv;
      vv = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      cyc("rand", 1'($urandom_range(0, 2) != 0), int'($urandom_range(0, 7)),
          int'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), vv, 4'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
